vedic_vec_mul_sched: RTL and testbench

- Time-multiplexes one shared WIDTH-bit Urdhva-Tiryakbhyam multiplier across the LANES elements of a vector operand pair.
- Accepts a whole vector pair via valid/ready, issues one lane per cycle to the multiplier and collects the in-order products.
- Presents the full product vector via valid/ready.
- Sits between the vector-op front end and a single instance of the pipelined vedic multiplier datapath.

---
 rtl/vedic_vec_mul_sched_pkg.sv | 27 ++
 rtl/vedic_vec_mul_sched_chk.sv | 16 +
 rtl/vedic_vec_mul_sched_issue_tag_pipe.sv | 34 +++
 rtl/vedic_vec_mul_sched.sv | 160 ++++++++++++++++
 tb/tb_vedic_vec_mul_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vedic_vec_mul_sched_pkg.sv
// Shared types and defaults for the vedic vector multiply scheduler.
package vedic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int unsigned VEDIC_WIDTH   = 32'd32;
  localparam int unsigned VEDIC_LANES   = 32'd4;
  localparam int unsigned VEDIC_MUL_LAT = 32'd2;

  // Width of a lane index; never narrower than one bit so LANES=2 still works.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    int unsigned w;
    w = 32'd1;
    if (lanes > 32'd2) begin
      w = $clog2(lanes);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vedic_vec_mul_sched_chk.sv
// Checker: a returning tag must only ever be seen while lanes are in flight.
module vedic_vec_mul_sched_chk
  import vedic_sched_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  input logic         tag_valid,
  input sched_state_t state
);

  a_tag_in_flight: assert property (
    @(posedge clk) disable iff (!rst_n)
      tag_valid |-> (state == ISSUE || state == DRAIN)
  );

endmodule

// File: rtl/vedic_vec_mul_sched_issue_tag_pipe.sv
// Delays the one-bit issue tag by DEPTH cycles so that it lines up with the
// product returned by the shared multiplier. DEPTH=0 is a straight wire.
module issue_tag_pipe #(
  parameter int unsigned DEPTH = 32'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tag_in,
  output logic tag_out
);

  if (DEPTH == 32'd0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;
    assign tag_out = tag_in;
  end else begin : g_pipe
    logic [DEPTH-1:0] stage_r;

    // Shift the tag one stage per cycle; reset flushes every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_r <= '0;
      end else begin
        stage_r[0] <= tag_in;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign tag_out = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vedic_vec_mul_sched.sv
// Time-multiplexes one shared WIDTH-bit multiplier across LANES operand
// lanes: accepts a vector pair, issues one lane per cycle, collects the
// in-order products and presents the full product vector.
module vedic_vec_mul_sched
  import vedic_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = VEDIC_WIDTH,
  parameter int unsigned LANES   = VEDIC_LANES,
  parameter int unsigned MUL_LAT = VEDIC_MUL_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     in_a,
  input  logic [LANES*WIDTH-1:0]     in_b,
  output logic                       mul_issue,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*2*WIDTH-1:0]   out_product,
  output logic                       busy
);

  localparam int unsigned IDX_W = lane_idx_w(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

  sched_state_t     state_r;
  logic [WIDTH-1:0] a_r [LANES];
  logic [WIDTH-1:0] b_r [LANES];
  logic [IDX_W-1:0] issue_idx_r;
  logic [IDX_W-1:0] coll_idx_r;
  logic             tag_valid;
  logic             capture_s;
  logic             last_capture_s;

  issue_tag_pipe #(
    .DEPTH (MUL_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (mul_issue),
    .tag_out (tag_valid)
  );

  vedic_vec_mul_sched_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_valid (tag_valid),
    .state     (state_r)
  );

  // A returning tag is only honoured while lanes are outstanding.
  always_comb begin
    capture_s      = 1'b0;
    last_capture_s = 1'b0;
    if (tag_valid && (state_r == ISSUE || state_r == DRAIN)) begin
      capture_s      = 1'b1;
      last_capture_s = (coll_idx_r == LAST_IDX);
    end else begin
      capture_s      = 1'b0;
      last_capture_s = 1'b0;
    end
  end

  // Scheduler FSM: capture operands, issue lanes, collect products, hand off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      mul_issue   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      issue_idx_r <= '0;
      coll_idx_r  <= '0;
      for (int i = 0; i < int'(LANES); i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
    end else begin
      // Collect an in-order return; lane position follows the collect index.
      if (capture_s) begin
        out_product[32'(coll_idx_r)*(2*WIDTH) +: 2*WIDTH] <= mul_result;
        coll_idx_r <= coll_idx_r + IDX_ONE;
      end

      case (state_r)
        IDLE: begin
          mul_issue <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          if (in_valid && in_ready) begin
            for (int i = 0; i < int'(LANES); i++) begin
              a_r[i] <= in_a[i*WIDTH +: WIDTH];
              b_r[i] <= in_b[i*WIDTH +: WIDTH];
            end
            out_product <= '0;
            issue_idx_r <= '0;
            coll_idx_r  <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ISSUE;
          end
        end

        ISSUE: begin
          mul_issue   <= 1'b1;
          mul_a       <= a_r[issue_idx_r];
          mul_b       <= b_r[issue_idx_r];
          issue_idx_r <= issue_idx_r + IDX_ONE;
          if (last_capture_s) begin
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else if (issue_idx_r == LAST_IDX) begin
            state_r   <= DRAIN;
          end
        end

        DRAIN: begin
          mul_issue <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          if (last_capture_s) begin
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end

        DONE: begin
          mul_issue <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end

        default: begin
          mul_issue <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_vec_mul_sched.sv
// Directed bench for vedic_vec_mul_sched: default configuration with a
// two-stage behavioural multiplier, plus a LANES=2 / MUL_LAT=0 instance with
// a combinational multiplier.
module tb_vedic_vec_mul_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Cycle counter: value read at a negedge equals number of rising edges seen.
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance signals
  logic         in_valid, in_ready, mul_issue, out_valid, out_ready, busy;
  logic [127:0] in_a, in_b;
  logic [31:0]  mul_a, mul_b;
  logic [63:0]  mul_result;
  logic [255:0] out_product;
  logic [63:0]  p1 = 64'd0;
  logic [63:0]  p2 = 64'd0;

  // Two-stage multiplier model: product valid two cycles after issue.
  always @(posedge clk) begin
    p1 <= 64'(mul_a) * 64'(mul_b);
    p2 <= p1;
  end
  assign mul_result = p2;

  vedic_vec_mul_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy)
  );

  // LANES=2, MUL_LAT=0 instance signals
  logic         in_valid2, in_ready2, mul_issue2, out_valid2, out_ready2, busy2;
  logic [63:0]  in_a2, in_b2;
  logic [31:0]  mul_a2, mul_b2;
  logic [63:0]  mul_result2;
  logic [127:0] out_product2;

  assign mul_result2 = 64'(mul_a2) * 64'(mul_b2);

  vedic_vec_mul_sched #(.WIDTH(32), .LANES(2), .MUL_LAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .mul_issue(mul_issue2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_result(mul_result2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_product(out_product2),
    .busy(busy2)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a vector pair for one edge; caller is at a negedge with dut idle.
  task automatic accept(input logic [127:0] a, input logic [127:0] b, output int t0);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    t0       = cyc;
    in_valid = 1'b0;
    check("accept busy", 256'(busy), 256'(1'b1));
    check("accept in_ready", 256'(in_ready), 256'(1'b0));
  endtask

  // Wait (bounded) for out_valid, checking latency, issue count, first lane and result.
  task automatic wait_done(input string tag, input int t0, input logic [31:0] a0,
                           input logic [31:0] b0, input logic [255:0] exp);
    int n;
    bit seen;
    logic [31:0] fa, fb;
    n = 0; seen = 1'b0; fa = '0; fb = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (mul_issue) begin
        if (n == 0) begin fa = mul_a; fb = mul_b; end
        n++;
      end
      if (out_valid) seen = 1'b1;
    end
    check({tag, " out_valid seen"}, 256'(seen), 256'(1'b1));
    check({tag, " latency"}, 256'(cyc - t0), 256'(7));
    check({tag, " issue cycles"}, 256'(n), 256'(4));
    check({tag, " lane0 a"}, 256'(fa), 256'(a0));
    check({tag, " lane0 b"}, 256'(fb), 256'(b0));
    check({tag, " product"}, out_product, exp);
  endtask

  initial begin
    int t0;
    int n2;
    bit seen2;
    rst_n     = 1'b0;
    in_valid  = 1'b0; in_a  = '0; in_b  = '0; out_ready  = 1'b1;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst in_ready", 256'(in_ready), 256'(1'b1));
    check("rst mul_issue", 256'(mul_issue), 256'(1'b0));
    check("rst mul_a", 256'(mul_a), 256'(0));
    check("rst mul_b", 256'(mul_b), 256'(0));
    check("rst out_valid", 256'(out_valid), 256'(1'b0));
    check("rst out_product", out_product, 256'(0));
    check("rst busy", 256'(busy), 256'(1'b0));
    check("rst2 in_ready", 256'(in_ready2), 256'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic vector: A={3,5,7,9}, B={2,4,6,8}
    accept({32'd9, 32'd7, 32'd5, 32'd3}, {32'd8, 32'd6, 32'd4, 32'd2}, t0);
    wait_done("basic", t0, 32'd3, 32'd2, {64'd72, 64'd42, 64'd20, 64'd6});
    @(negedge clk);
    check("basic idle out_valid", 256'(out_valid), 256'(1'b0));
    check("basic idle in_ready", 256'(in_ready), 256'(1'b1));
    check("basic idle busy", 256'(busy), 256'(1'b0));

    // Max operands: no truncation of the full 64-bit product
    accept({4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, t0);
    wait_done("max", t0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {4{64'hFFFF_FFFE_0000_0001}});
    @(negedge clk);

    // Backpressure: hold DONE for 10 cycles, stray in_valid must be ignored
    out_ready = 1'b0;
    accept({32'd4, 32'd3, 32'd2, 32'd1}, {32'd400, 32'd300, 32'd200, 32'd100}, t0);
    wait_done("bp", t0, 32'd1, 32'd100, {64'd1600, 64'd900, 64'd400, 64'd100});
    in_valid = 1'b1;
    in_a     = {4{32'd7}};
    in_b     = {4{32'd7}};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp hold out_valid", 256'(out_valid), 256'(1'b1));
      check("bp hold product", out_product, {64'd1600, 64'd900, 64'd400, 64'd100});
      check("bp hold in_ready", 256'(in_ready), 256'(1'b0));
      check("bp hold mul_issue", 256'(mul_issue), 256'(1'b0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 256'(out_valid), 256'(1'b0));
    check("bp release in_ready", 256'(in_ready), 256'(1'b1));
    check("bp release busy", 256'(busy), 256'(1'b0));

    // Busy ignore: second vector held valid during ISSUE, accepted only from IDLE
    accept({32'd14, 32'd13, 32'd12, 32'd11}, {4{32'd2}}, t0);
    in_valid = 1'b1;
    in_a     = {4{32'd1}};
    in_b     = {4{32'd5}};
    wait_done("ignore first", t0, 32'd11, 32'd2, {64'd28, 64'd26, 64'd24, 64'd22});
    @(negedge clk);
    check("ignore idle in_ready", 256'(in_ready), 256'(1'b1));
    check("ignore idle out_valid", 256'(out_valid), 256'(1'b0));
    @(negedge clk);
    t0 = cyc;
    in_valid = 1'b0;
    check("ignore second accepted", 256'(busy), 256'(1'b1));
    wait_done("ignore second", t0, 32'd1, 32'd5, {4{64'd5}});
    @(negedge clk);

    // Reset mid-DRAIN after two lanes were captured
    accept({32'd9, 32'd7, 32'd5, 32'd3}, {32'd8, 32'd6, 32'd4, 32'd2}, t0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 256'(in_ready), 256'(1'b1));
    check("midrst mul_issue", 256'(mul_issue), 256'(1'b0));
    check("midrst mul_a", 256'(mul_a), 256'(0));
    check("midrst out_valid", 256'(out_valid), 256'(1'b0));
    check("midrst out_product", out_product, 256'(0));
    check("midrst busy", 256'(busy), 256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("late return product", out_product, 256'(0));
    check("late return out_valid", 256'(out_valid), 256'(1'b0));
    check("late return busy", 256'(busy), 256'(1'b0));
    accept({32'd5, 32'd4, 32'd3, 32'd2}, {4{32'd7}}, t0);
    wait_done("after reset", t0, 32'd2, 32'd7, {64'd35, 64'd28, 64'd21, 64'd14});
    @(negedge clk);

    // LANES=2, MUL_LAT=0: A={10,0}, B={10,123}
    in_valid2 = 1'b1;
    in_a2     = {32'd0, 32'd10};
    in_b2     = {32'd123, 32'd10};
    @(negedge clk);
    t0 = cyc;
    in_valid2 = 1'b0;
    check("sweep accept busy", 256'(busy2), 256'(1'b1));
    n2 = 0; seen2 = 1'b0;
    for (int k = 0; k < 40 && !seen2; k++) begin
      @(negedge clk);
      if (mul_issue2) n2++;
      if (out_valid2) seen2 = 1'b1;
    end
    check("sweep out_valid seen", 256'(seen2), 256'(1'b1));
    check("sweep latency", 256'(cyc - t0), 256'(3));
    check("sweep issue cycles", 256'(n2), 256'(2));
    check("sweep product", 256'(out_product2), 256'({64'd0, 64'd100}));
    @(negedge clk);
    check("sweep idle in_ready", 256'(in_ready2), 256'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the run hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
